// File: rtl/axi_lite_mem_master.sv
// Single-outstanding master: turns core load/store requests into AW/W/B and AR/R handshakes for the RAM slave.
// Define AXI_MASTER_PERF_EN to add load/store/stall performance counter outputs.
module axi_lite_mem_master #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned STRB_W = DATA_W / 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_req_valid,
    output logic              io_req_ready,
    input  logic              io_req_wen,
    input  logic [ADDR_W-1:0] io_req_addr,
    input  logic [DATA_W-1:0] io_req_wdata,
    input  logic [STRB_W-1:0] io_req_wstrb,
    output logic              io_resp_valid,
    output logic [DATA_W-1:0] io_resp_rdata,
    output logic              io_busy,
    output logic [ADDR_W-1:0] io_awaddr,
    output logic              io_awvalid,
    input  logic              io_awready,
    output logic [DATA_W-1:0] io_wdata,
    output logic [STRB_W-1:0] io_wstrb,
    output logic              io_wvalid,
    input  logic              io_wready,
    input  logic              io_bvalid,
    output logic [ADDR_W-1:0] io_araddr,
    output logic              io_arvalid,
    input  logic              io_arready,
    input  logic [DATA_W-1:0] io_rdata
`ifdef AXI_MASTER_PERF_EN
   ,output logic [31:0]       io_perf_rd_cnt,
    output logic [31:0]       io_perf_wr_cnt,
    output logic [31:0]       io_perf_stall_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        rdata_d       = rdata_q;
        io_req_ready  = 1'b0;
        io_arvalid    = 1'b0;
        io_awvalid    = 1'b0;
        io_wvalid     = 1'b0;
        io_resp_valid = 1'b0;

        case (state_q)
            IDLE: begin
                io_req_ready = 1'b1;
                if (io_req_valid) begin
                    addr_d    = io_req_addr;
                    wdata_d   = io_req_wdata;
                    wstrb_d   = io_req_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = io_req_wen ? WR_REQ : RD_ADDR;
                end
            end
            RD_ADDR: begin
                io_arvalid = 1'b1;
                if (io_arready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                // Slave presents read data exactly one cycle after the AR handshake.
                rdata_d = io_rdata;
                state_d = DONE;
            end
            WR_REQ: begin
                io_awvalid = !aw_done_q;
                io_wvalid  = !w_done_q;
                if (io_awvalid && io_awready) begin
                    aw_done_d = 1'b1;
                end
                if (io_wvalid && io_wready) begin
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (io_bvalid) begin
                    rdata_d = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                io_resp_valid = 1'b1;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign io_busy       = (state_q != IDLE) || io_req_valid;
    assign io_awaddr     = addr_q;
    assign io_araddr     = addr_q;
    assign io_wdata      = wdata_q;
    assign io_wstrb      = wstrb_q;
    assign io_resp_rdata = rdata_q;

`ifdef AXI_MASTER_PERF_EN
    logic        wen_q;
    logic [31:0] rd_cnt_q, wr_cnt_q, stall_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wen_q       <= 1'b0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (state_q == IDLE && io_req_valid) begin
                wen_q <= io_req_wen;
            end
            if (state_q == DONE && !wen_q) begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
            if (state_q == DONE && wen_q) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
            if (io_busy) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign io_perf_rd_cnt    = rd_cnt_q;
    assign io_perf_wr_cnt    = wr_cnt_q;
    assign io_perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_axi_lite_mem_master.sv
// Self-checking bench for axi_lite_mem_master with a reactive slave model and a response scoreboard.
`timescale 1ns/1ps
module tb_axi_lite_mem_master;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned STRB_W = 8;
    localparam logic [63:0] GARB   = 64'hBADBADBADBADBAD0;

    logic              clock = 1'b0;
    logic              reset;
    logic              io_req_valid, io_req_ready, io_req_wen;
    logic [ADDR_W-1:0] io_req_addr;
    logic [DATA_W-1:0] io_req_wdata;
    logic [STRB_W-1:0] io_req_wstrb;
    logic              io_resp_valid;
    logic [DATA_W-1:0] io_resp_rdata;
    logic              io_busy;
    logic [ADDR_W-1:0] io_awaddr, io_araddr;
    logic              io_awvalid, io_awready, io_wvalid, io_wready, io_bvalid;
    logic [DATA_W-1:0] io_wdata, io_rdata;
    logic [STRB_W-1:0] io_wstrb;
    logic              io_arvalid, io_arready;
`ifdef AXI_MASTER_PERF_EN
    logic [31:0]       io_perf_rd_cnt, io_perf_wr_cnt, io_perf_stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    // Slave model knobs and state
    int          ar_wait, aw_wait, w_wait, b_wait;
    bit          ar_always, b_early;
    logic [63:0] rd_value;
    int          ar_cnt, aw_cnt, w_cnt, b_cnt, stab_err;
    bit          ar_pend, aw_pend, w_pend, aw_acc, w_acc;
    bit          snap_ar, snap_aw, snap_w;
    logic [31:0] snap_araddr, snap_awaddr;
    logic [63:0] snap_wdata;
    logic [7:0]  snap_wstrb;

    axi_lite_mem_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) dut (
        .clock(clock), .reset(reset),
        .io_req_valid(io_req_valid), .io_req_ready(io_req_ready), .io_req_wen(io_req_wen),
        .io_req_addr(io_req_addr), .io_req_wdata(io_req_wdata), .io_req_wstrb(io_req_wstrb),
        .io_resp_valid(io_resp_valid), .io_resp_rdata(io_resp_rdata), .io_busy(io_busy),
        .io_awaddr(io_awaddr), .io_awvalid(io_awvalid), .io_awready(io_awready),
        .io_wdata(io_wdata), .io_wstrb(io_wstrb), .io_wvalid(io_wvalid), .io_wready(io_wready),
        .io_bvalid(io_bvalid), .io_araddr(io_araddr), .io_arvalid(io_arvalid),
        .io_arready(io_arready), .io_rdata(io_rdata)
`ifdef AXI_MASTER_PERF_EN
       ,.io_perf_rd_cnt(io_perf_rd_cnt), .io_perf_wr_cnt(io_perf_wr_cnt),
        .io_perf_stall_cnt(io_perf_stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Slave decisions are made on the falling edge for the following rising edge.
    always @(negedge clock) begin
        if (reset) begin
            io_arready = 1'b0; io_awready = 1'b0; io_wready = 1'b0; io_bvalid = 1'b0;
            io_rdata = GARB;
            ar_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            ar_pend = 0; aw_pend = 0; w_pend = 0; aw_acc = 0; w_acc = 0;
            snap_ar = 0; snap_aw = 0; snap_w = 0;
        end else begin
            if (snap_ar && (!io_arvalid || io_araddr !== snap_araddr)) stab_err++;
            if (snap_aw && (!io_awvalid || io_awaddr !== snap_awaddr)) stab_err++;
            if (snap_w && (!io_wvalid || io_wdata !== snap_wdata || io_wstrb !== snap_wstrb)) stab_err++;
            io_rdata = ar_pend ? rd_value : GARB;
            ar_pend = 0;
            if (aw_pend) aw_acc = 1;
            if (w_pend) w_acc = 1;
            aw_pend = 0; w_pend = 0;

            io_arready = ar_always || (io_arvalid && ar_cnt >= ar_wait);
            if (io_arvalid && !io_arready) ar_cnt++;
            if (io_arvalid && io_arready) begin ar_pend = 1; ar_cnt = 0; end

            io_awready = io_awvalid && aw_cnt >= aw_wait;
            if (io_awvalid && !io_awready) aw_cnt++;
            if (io_awvalid && io_awready) begin aw_pend = 1; aw_cnt = 0; end

            io_wready = io_wvalid && w_cnt >= w_wait;
            if (io_wvalid && !io_wready) w_cnt++;
            if (io_wvalid && io_wready) begin w_pend = 1; w_cnt = 0; end

            if (aw_acc && w_acc) begin
                if (b_cnt >= b_wait) begin
                    io_bvalid = 1'b1; aw_acc = 0; w_acc = 0; b_cnt = 0;
                end else begin
                    io_bvalid = 1'b0; b_cnt++;
                end
            end else if (b_early && aw_acc) begin
                io_bvalid = 1'b1; b_early = 0;
            end else begin
                io_bvalid = 1'b0;
            end

            snap_ar = io_arvalid && !io_arready; snap_araddr = io_araddr;
            snap_aw = io_awvalid && !io_awready; snap_awaddr = io_awaddr;
            snap_w  = io_wvalid && !io_wready;   snap_wdata = io_wdata; snap_wstrb = io_wstrb;
        end
    end

    task automatic set_slave(input int arw, input int aww, input int ww, input int bw,
                             input bit ara, input bit be);
        ar_wait = arw; aw_wait = aww; w_wait = ww; b_wait = bw; ar_always = ara; b_early = be;
        stab_err = 0;
    endtask

    task automatic drive_req(input logic wen, input logic [31:0] addr, input logic [63:0] wd,
                             input logic [7:0] ws);
        io_req_valid = 1'b1; io_req_wen = wen; io_req_addr = addr;
        io_req_wdata = wd; io_req_wstrb = ws;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({io_awvalid, io_wvalid, io_arvalid, io_resp_valid} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_valids: got %b expected 0000", {io_awvalid, io_wvalid, io_arvalid, io_resp_valid});
        end
        n_checks++;
        if (io_req_ready !== 1'b1 || io_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready_busy: got ready=%b busy=%b expected 1/0", io_req_ready, io_busy);
        end
        n_checks++;
        if (io_resp_rdata !== 64'd0 || io_awaddr !== 32'd0 || io_wdata !== 64'd0 || io_wstrb !== 8'd0) begin
            n_fail++; $display("FAIL reset_regs: got rdata=%h addr=%h wdata=%h wstrb=%h expected 0", io_resp_rdata, io_awaddr, io_wdata, io_wstrb);
        end
    endtask

    task automatic test_load_zero_wait();
        logic [63:0] exp;
        int got = 0;
        set_slave(0, 0, 0, 0, 1, 0);
        rd_value = 64'h1122334455667788;
        @(negedge clock);
        drive_req(1'b0, 32'h80000010, 64'h0, 8'hFF);
        exp_q.push_back(rd_value);
        #1;
        n_checks++;
        if (io_busy !== 1'b1 || io_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL load_idle_busy: got busy=%b ready=%b expected 1/1", io_busy, io_req_ready);
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            if (k == 1) begin
                io_req_valid = 1'b0;
                n_checks++;
                if (io_arvalid !== 1'b1 || io_araddr !== 32'h80000010) begin
                    n_fail++; $display("FAIL load_ar: got arvalid=%b araddr=%h expected 1/80000010", io_arvalid, io_araddr);
                end
            end
            if (k <= 3) begin
                n_checks++;
                if (io_req_ready !== 1'b0) begin
                    n_fail++; $display("FAIL load_ready_low: cycle %0d got %b expected 0", k, io_req_ready);
                end
            end
            if (io_resp_valid) begin
                got++;
                n_checks++;
                if (k != 3) begin n_fail++; $display("FAIL load_latency: got cycle %0d expected 3", k); end
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL load_sb: unexpected response rdata=%h", io_resp_rdata);
                end else begin
                    exp = exp_q.pop_front();
                    if (io_resp_rdata !== exp) begin
                        n_fail++; $display("FAIL load_rdata: got %h expected %h", io_resp_rdata, exp);
                    end
                end
            end
        end
        n_checks++;
        if (got != 1) begin n_fail++; $display("FAIL load_pulses: got %0d expected 1", got); end
    endtask

    task automatic test_store_split();
        logic [63:0] exp;
        int got = 0;
        set_slave(0, 0, 3, 1, 0, 1);
        @(negedge clock);
        drive_req(1'b1, 32'h80000200, 64'hDEADBEEF00000000, 8'hF0);
        exp_q.push_back(64'd0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (k == 1) io_req_valid = 1'b0;
            if (k <= 6) begin
                n_checks++;
                if (io_awvalid !== (k == 1) || io_wvalid !== (k <= 4)) begin
                    n_fail++; $display("FAIL store_valids: cycle %0d got aw=%b w=%b expected %b/%b", k, io_awvalid, io_wvalid, k == 1, k <= 4);
                end
                if (io_awvalid === 1'b1) begin
                    n_checks++;
                    if (io_awaddr !== 32'h80000200) begin
                        n_fail++; $display("FAIL store_awaddr: got %h expected 80000200", io_awaddr);
                    end
                end
                if (io_wvalid === 1'b1) begin
                    n_checks++;
                    if (io_wdata !== 64'hDEADBEEF00000000 || io_wstrb !== 8'hF0) begin
                        n_fail++; $display("FAIL store_wdata: got %h/%h expected deadbeef00000000/f0", io_wdata, io_wstrb);
                    end
                end
            end
            if (io_resp_valid) begin
                got++;
                n_checks++;
                if (k != 7) begin n_fail++; $display("FAIL store_latency: got cycle %0d expected 7", k); end
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL store_sb: unexpected response rdata=%h", io_resp_rdata);
                end else begin
                    exp = exp_q.pop_front();
                    if (io_resp_rdata !== exp) begin
                        n_fail++; $display("FAIL store_rdata: got %h expected %h", io_resp_rdata, exp);
                    end
                end
            end
        end
        n_checks++;
        if (got != 1) begin n_fail++; $display("FAIL store_pulses: got %0d expected 1", got); end
        n_checks++;
        if (stab_err != 0) begin n_fail++; $display("FAIL store_stable: got %0d violations expected 0", stab_err); end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp;
        int got = 0;
        set_slave(5, 0, 0, 0, 0, 0);
        rd_value = 64'hA5A5A5A55A5A5A5A;
        @(negedge clock);
        drive_req(1'b0, 32'h00001234, 64'h0, 8'h00);
        exp_q.push_back(rd_value);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (k == 1) io_req_valid = 1'b0;
            if (k <= 6) begin
                n_checks++;
                if (io_arvalid !== 1'b1 || io_araddr !== 32'h00001234) begin
                    n_fail++; $display("FAIL bp_ar_stable: cycle %0d got arvalid=%b araddr=%h expected 1/00001234", k, io_arvalid, io_araddr);
                end
            end
            if (io_resp_valid) begin
                got++;
                n_checks++;
                if (k != 8) begin n_fail++; $display("FAIL bp_latency: got cycle %0d expected 8", k); end
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL bp_sb: unexpected response rdata=%h", io_resp_rdata);
                end else begin
                    exp = exp_q.pop_front();
                    if (io_resp_rdata !== exp) begin
                        n_fail++; $display("FAIL bp_rdata: got %h expected %h", io_resp_rdata, exp);
                    end
                end
            end
        end
        n_checks++;
        if (got != 1 || stab_err != 0) begin
            n_fail++; $display("FAIL bp_pulses: got pulses=%0d stab_err=%0d expected 1/0", got, stab_err);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [63:0] exp;
        int got = 0;
        set_slave(0, 0, 0, 3, 0, 0);
        @(negedge clock);
        drive_req(1'b1, 32'h80000300, 64'h0123456789ABCDEF, 8'hFF);
        exp_q.push_back(64'd0);
        @(negedge clock);
        io_req_valid = 1'b0;
        @(negedge clock);
        n_checks++;
        if (io_req_ready !== 1'b0 || io_busy !== 1'b1 || io_awvalid !== 1'b0 || io_wvalid !== 1'b0) begin
            n_fail++; $display("FAIL rst_wr_resp_state: got ready=%b busy=%b aw=%b w=%b expected 0/1/0/0", io_req_ready, io_busy, io_awvalid, io_wvalid);
        end
        #2 reset = 1'b1;
        #1;
        exp_q.delete();
        n_checks++;
        if ({io_awvalid, io_wvalid, io_arvalid, io_resp_valid} !== 4'b0000 || io_req_ready !== 1'b1 || io_busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_async: got valids=%b ready=%b busy=%b expected 0000/1/0", {io_awvalid, io_wvalid, io_arvalid, io_resp_valid}, io_req_ready, io_busy);
        end
        n_checks++;
        if (io_resp_rdata !== 64'd0 || io_awaddr !== 32'd0) begin
            n_fail++; $display("FAIL rst_regs: got rdata=%h addr=%h expected 0/0", io_resp_rdata, io_awaddr);
        end
        @(negedge clock);
        #2 reset = 1'b0;
        set_slave(1, 0, 0, 0, 0, 0);
        rd_value = 64'hCAFEF00D12345678;
        @(negedge clock);
        drive_req(1'b0, 32'h80000400, 64'h0, 8'h00);
        exp_q.push_back(rd_value);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (k == 1) io_req_valid = 1'b0;
            if (io_resp_valid) begin
                got++;
                n_checks++;
                if (k != 4) begin n_fail++; $display("FAIL rst_load_latency: got cycle %0d expected 4", k); end
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rst_load_sb: unexpected response rdata=%h", io_resp_rdata);
                end else begin
                    exp = exp_q.pop_front();
                    if (io_resp_rdata !== exp) begin
                        n_fail++; $display("FAIL rst_load_rdata: got %h expected %h", io_resp_rdata, exp);
                    end
                end
            end
        end
        n_checks++;
        if (got != 1) begin n_fail++; $display("FAIL rst_load_pulses: got %0d expected 1", got); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp;
        int got = 0;
        int acc_k = 0;
        set_slave(0, 0, 0, 0, 0, 0);
        rd_value = 64'h0102030405060708;
        @(negedge clock);
        drive_req(1'b0, 32'h80000500, 64'h0, 8'h00);
        exp_q.push_back(rd_value);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            if (k == 1) begin
                drive_req(1'b1, 32'h80000508, 64'h55AA55AA00FF00FF, 8'h0F);
                exp_q.push_back(64'd0);
            end
            if (acc_k != 0) io_req_valid = 1'b0;
            if (io_req_ready && io_req_valid && acc_k == 0) acc_k = k;
            if (k <= 7) begin
                n_checks++;
                if (io_req_ready !== (k == 4)) begin
                    n_fail++; $display("FAIL b2b_ready: cycle %0d got %b expected %b", k, io_req_ready, k == 4);
                end
            end
            if (k == 5) begin
                n_checks++;
                if (io_awvalid !== 1'b1 || io_awaddr !== 32'h80000508 || io_wdata !== 64'h55AA55AA00FF00FF) begin
                    n_fail++; $display("FAIL b2b_store_issue: got aw=%b addr=%h wdata=%h expected 1/80000508/55aa55aa00ff00ff", io_awvalid, io_awaddr, io_wdata);
                end
            end
            if (io_resp_valid) begin
                got++;
                n_checks++;
                if (!((got == 1 && k == 3) || (got == 2 && k == 7))) begin
                    n_fail++; $display("FAIL b2b_latency: pulse %0d at cycle %0d expected cycles 3 and 7", got, k);
                end
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_sb: unexpected response rdata=%h", io_resp_rdata);
                end else begin
                    exp = exp_q.pop_front();
                    if (io_resp_rdata !== exp) begin
                        n_fail++; $display("FAIL b2b_rdata: got %h expected %h", io_resp_rdata, exp);
                    end
                end
            end
        end
        n_checks++;
        if (got != 2 || acc_k != 4) begin
            n_fail++; $display("FAIL b2b_count: got pulses=%0d accept_cycle=%0d expected 2/4", got, acc_k);
        end
    endtask

`ifdef AXI_MASTER_PERF_EN
    task automatic test_perf();
        int got = 0;
        logic [63:0] exp;
        @(negedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        #2 reset = 1'b0;
        set_slave(0, 0, 0, 0, 0, 0);
        rd_value = 64'h0F0F0F0F0F0F0F0F;
        for (int r = 0; r < 3; r++) begin
            @(negedge clock);
            drive_req(r == 2, 32'h80000600 + r * 8, 64'h1111, 8'hFF);
            exp_q.push_back(r == 2 ? 64'd0 : rd_value);
            @(negedge clock);
            io_req_valid = 1'b0;
            for (int k = 2; k <= 8 && !io_resp_valid; k++) @(negedge clock);
            n_checks++;
            if (!io_resp_valid || exp_q.size() == 0) begin
                n_fail++; $display("FAIL perf_resp: request %0d got no response, expected one", r);
            end else begin
                got++;
                exp = exp_q.pop_front();
                if (io_resp_rdata !== exp) begin
                    n_fail++; $display("FAIL perf_rdata: got %h expected %h", io_resp_rdata, exp);
                end
            end
        end
        @(negedge clock);
        n_checks++;
        if (io_perf_rd_cnt !== 32'd2 || io_perf_wr_cnt !== 32'd1 || io_perf_stall_cnt !== 32'd12) begin
            n_fail++; $display("FAIL perf_counters: got rd=%0d wr=%0d stall=%0d expected 2/1/12", io_perf_rd_cnt, io_perf_wr_cnt, io_perf_stall_cnt);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        io_req_valid = 1'b0; io_req_wen = 1'b0; io_req_addr = '0; io_req_wdata = '0; io_req_wstrb = '0;
        io_arready = 1'b0; io_awready = 1'b0; io_wready = 1'b0; io_bvalid = 1'b0; io_rdata = GARB;
        rd_value = '0;
        set_slave(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        test_reset();
        test_load_zero_wait();
        test_store_split();
        test_backpressure();
        test_reset_mid_write();
        test_back_to_back();
`ifdef AXI_MASTER_PERF_EN
        test_perf();
`endif
        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_mem_master.md
Name: axi_lite_mem_master

Overview:
- Upstream master that feeds the simplified AXI4 RAM slave in the five-stage core's memory system.
- Converts single-beat load/store requests from the core's MEM stage (or a fetch arbiter) into that slave's AW/W/B and AR/R-data channel handshakes.
- Holds at most one transaction in flight.
- Returns one response pulse per request, with read data captured from the slave.

Parameters:
- ADDR_W, 32, address width on both sides
- DATA_W, 64, data beat width
- STRB_W, DATA_W/8, byte-strobe width

Ports:
- clock  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- io_req_valid  in  1  core request valid
- io_req_ready  out  1  bridge can accept a request this cycle
- io_req_wen  in  1  1 = store, 0 = load
- io_req_addr  in  ADDR_W  byte address
- io_req_wdata  in  DATA_W  store data
- io_req_wstrb  in  STRB_W  store byte enables
- io_resp_valid  out  1  one-cycle completion pulse
- io_resp_rdata  out  DATA_W  load data (0 for stores)
- io_busy  out  1  transaction in flight (core stall source)
- io_awaddr  out  ADDR_W  write address
- io_awvalid  out  1  write address valid
- io_awready  in  1  slave accepts AW
- io_wdata  out  DATA_W  write data
- io_wstrb  out  STRB_W  write strobes
- io_wvalid  out  1  write data valid
- io_wready  in  1  slave accepts W
- io_bvalid  in  1  write response
- io_araddr  out  ADDR_W  read address
- io_arvalid  out  1  read address valid
- io_arready  in  1  slave accepts AR
- io_rdata  in  DATA_W  slave read data

Behaviour:
- Clocking and reset:
  - One clock domain, clock.
  - reset is asynchronous and active-high.
  - On reset: state=IDLE; all valids (awvalid, wvalid, arvalid, resp_valid) = 0; resp_rdata = 0; captured address/data/strobe registers = 0; io_busy = 0.
  - io_req_ready = 1 after reset.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE:
  - io_req_ready = 1.
  - On io_req_valid, latch addr, wdata, wstrb and wen.
  - wen=0 -> RD_ADDR; wen=1 -> WR_REQ, with aw_done=0 and w_done=0.
  - Response latency is therefore at least 1 cycle after acceptance.
- RD_ADDR:
  - arvalid=1 and araddr=latched addr, both held stable until arready.
  - On arvalid&&arready -> RD_DATA.
- RD_DATA:
  - The slave's io_rdata is valid in the cycle after the AR handshake.
  - Capture it into resp_rdata -> DONE.
- WR_REQ:
  - awvalid = !aw_done; wvalid = !w_done.
  - AW and W may complete in the same or in different cycles.
  - Each sets its done flag on handshake and deasserts its valid the following cycle.
  - awaddr, wdata and wstrb are held stable while the corresponding valid is high.
  - When both are done (including both in the same cycle) -> WR_RESP.
- WR_RESP: wait for io_bvalid -> DONE, with resp_rdata=0. A bvalid arriving before WR_RESP is ignored.
- DONE:
  - io_resp_valid=1 for exactly one cycle -> IDLE.
  - resp_rdata holds its value until the next response.
- Handshake and status:
  - io_req_ready=0 in every state except IDLE. No request queuing; back-to-back requests are spaced by at least the transaction length.
  - io_busy = (state != IDLE) || (IDLE && io_req_valid).
  - Minimum cycles from request accept to resp_valid: load 3 (RD_ADDR, RD_DATA, DONE); store 3 (WR_REQ, WR_RESP, DONE).
- Address and width:
  - Addresses pass through unmodified; no alignment or strobe checks.
  - No arithmetic besides flag updates.
- Reset mid-operation: asynchronous return to IDLE with all valids low immediately. The slave-side transaction is abandoned; the slave is reset by the same signal.
- Simultaneous events:
  - arready held high continuously is legal.
  - bvalid high in the same cycle as the final AW/W handshake is not consumed; the slave asserts bvalid only after both are accepted.

Optional Feature:
- Macro AXI_MASTER_PERF_EN. When defined, adds:
  - Ports: io_perf_rd_cnt, io_perf_wr_cnt, io_perf_stall_cnt, 32-bit outputs each.
  - Counters: completed loads, completed stores, and cycles with io_busy=1.
  - All three reset to 0, wrap on overflow, and increment in the DONE cycle (stall counter: every busy cycle).
- When undefined: ports and counters are absent; functional behaviour is identical.

Test Plan:
- Load, zero-wait: slave arready=1, io_rdata=0x1122334455667788 one cycle after the AR handshake, req addr 0x80000010 -> araddr=0x80000010; resp_valid 3 cycles after acceptance with rdata 0x1122334455667788; req_ready low throughout.
- Store, split handshake: awready=1 in cycle 1, wready delayed to cycle 4, bvalid in cycle 6; wdata=0xDEADBEEF00000000, wstrb=0xF0 -> awvalid drops after cycle 1, wvalid held through cycle 4; single resp_valid after bvalid with rdata=0.
- Back-pressure: arready low for 5 cycles -> arvalid and araddr stable all 5 cycles; no resp_valid until the handshake plus 2 cycles.
- Back-to-back: load then store with req_valid held high -> second request accepted only in the cycle req_ready returns (after resp_valid); exactly two resp_valid pulses.
- Reset mid-write: assert reset while in WR_RESP -> awvalid/wvalid/resp_valid=0 and req_ready=1 immediately; the next load completes normally.
- AXI_MASTER_PERF_EN defined: 2 loads and 1 store with 4 total stall cycles each -> rd_cnt=2, wr_cnt=1, stall_cnt equal to the sum of busy cycles.
